// File: rtl/key_mode_ctrl_pkg.sv
// key_pkg: shared types and defaults for the key front end.
// Holds channel FSM states, 50 MHz timing defaults and the sel->mode map.
package key_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_HOLD  = 2'd2
    } key_st_t;

    // 20 ms debounce, 1 s long press, 200 ms repeat at 50 MHz
    localparam int unsigned CNT_MAX_DEF  = 999_999;
    localparam int unsigned LONG_MAX_DEF = 49_999_999;
    localparam int unsigned REP_MAX_DEF  = 9_999_999;

    typedef enum logic [1:0] {
        MODE_SINE   = 2'd0,
        MODE_TRI    = 2'd1,
        MODE_SAW    = 2'd2,
        MODE_SQUARE = 2'd3
    } wave_mode_t;

    // One-hot sel (4-key board) to waveform; zero sel falls back to sine
    function automatic wave_mode_t sel_to_mode(input logic [3:0] s);
        wave_mode_t m;
        m = MODE_SINE;
        unique case (1'b1)
            s[0]:    m = MODE_SINE;
            s[1]:    m = MODE_TRI;
            s[2]:    m = MODE_SAW;
            s[3]:    m = MODE_SQUARE;
            default: m = MODE_SINE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/key_mode_ctrl_if.sv
// key_mode_if: key pins in, debounced events and mode select out.
// master = key_mode_ctrl (drives events), slave = board/consumer side.
interface key_mode_if #(
    parameter int NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] key;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_long;
    logic [NUM_KEYS-1:0] key_rep;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] sel;
    logic                sel_chg;

    modport master (
        input  key,
        output key_press,
        output key_long,
        output key_rep,
        output key_level,
        output sel,
        output sel_chg
    );

    modport slave (
        output key,
        input  key_press,
        input  key_long,
        input  key_rep,
        input  key_level,
        input  sel,
        input  sel_chg
    );
endinterface

// File: rtl/key_mode_ctrl_chan.sv
// key_chan: one key channel: sync, debounce, IDLE/PRESS/HOLD FSM.
// Ports: sys_clk, rst, key_n (raw, active low) -> level, press, long, rep.
module key_chan
    import key_pkg::*;
#(
    parameter int unsigned CNT_MAX  = CNT_MAX_DEF,
    parameter int unsigned LONG_MAX = LONG_MAX_DEF,
    parameter int unsigned REP_MAX  = REP_MAX_DEF
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic key_n,
    output logic level,
    output logic press,
    output logic long,
    output logic rep
);

    localparam int unsigned HMAX =
        (LONG_MAX > REP_MAX) ? LONG_MAX : REP_MAX;
    localparam int DW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam int HW = (HMAX > 0) ? $clog2(HMAX + 1) : 1;

    // Inverted before the flops so a reset synchroniser reads "released";
    // a key held through reset then debounces in as a fresh press.
    logic [1:0]    sync_q;
    logic          sync_lvl;
    logic [DW-1:0] db_cnt;
    logic          level_d;

    assign sync_lvl = sync_q[1];

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            db_cnt  <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], ~key_n};
            level_d <= level;
            if (sync_lvl == level) begin
                db_cnt <= '0;
            end else if (db_cnt == DW'(CNT_MAX)) begin
                level  <= ~level;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    logic rise;
    logic fall;

    assign rise = level & ~level_d;
    assign fall = ~level & level_d;

    key_st_t       state;
    key_st_t       state_nxt;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_nxt;
    logic          press_nxt;
    logic          long_nxt;
    logic          rep_nxt;
    logic          long_hit;
    logic          rep_hit;

    assign long_hit = (hold_cnt == HW'(LONG_MAX));
    assign rep_hit  = (hold_cnt == HW'(REP_MAX));

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
            press    <= 1'b0;
            long     <= 1'b0;
            rep      <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            press    <= press_nxt;
            long     <= long_nxt;
            rep      <= rep_nxt;
        end
    end

    // Release is checked first so it beats a coincident threshold hit.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (rise)
                    state_nxt = ST_PRESS;
            end
            ST_PRESS: begin
                if (fall)
                    state_nxt = ST_IDLE;
                else if (long_hit)
                    state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (fall)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        hold_nxt  = '0;
        press_nxt = 1'b0;
        long_nxt  = 1'b0;
        rep_nxt   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                press_nxt = rise;
            end
            ST_PRESS: begin
                if (!fall) begin
                    if (long_hit)
                        long_nxt = 1'b1;
                    else
                        hold_nxt = hold_cnt + 1'b1;
                end
            end
            ST_HOLD: begin
                if (!fall) begin
                    if (rep_hit)
                        rep_nxt = 1'b1;
                    else
                        hold_nxt = hold_cnt + 1'b1;
                end
            end
            default: hold_nxt = '0;
        endcase
    end

endmodule

// File: rtl/key_mode_ctrl.sv
// key_mode_ctrl: NUM_KEYS debounced keys plus one-hot mode select.
// Ports: sys_clk, rst (async, high), bus (key_mode_if.master).
module key_mode_ctrl
    import key_pkg::*;
#(
    parameter int unsigned          NUM_KEYS  = 4,
    parameter int unsigned          CNT_MAX   = CNT_MAX_DEF,
    parameter int unsigned          LONG_MAX  = LONG_MAX_DEF,
    parameter int unsigned          REP_MAX   = REP_MAX_DEF,
    parameter logic [NUM_KEYS-1:0]  RESET_SEL = '0
) (
    input  logic       sys_clk,
    input  logic       rst,
    key_mode_if.master bus
);

    logic [NUM_KEYS-1:0] press_v;
    logic [NUM_KEYS-1:0] long_v;
    logic [NUM_KEYS-1:0] rep_v;
    logic [NUM_KEYS-1:0] level_v;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
        key_chan #(
            .CNT_MAX  (CNT_MAX),
            .LONG_MAX (LONG_MAX),
            .REP_MAX  (REP_MAX)
        ) u_chan (
            .sys_clk (sys_clk),
            .rst     (rst),
            .key_n   (bus.key[i]),
            .level   (level_v[i]),
            .press   (press_v[i]),
            .long    (long_v[i]),
            .rep     (rep_v[i])
        );
    end

    // Lowest pressed index wins when several presses land together.
    logic [NUM_KEYS-1:0] sel_nxt;
    logic                hit;

    always_comb begin
        sel_nxt = '0;
        hit     = 1'b0;
        for (int i = 0; i < int'(NUM_KEYS); i++) begin
            if (press_v[i] && !hit) begin
                sel_nxt[i] = 1'b1;
                hit        = 1'b1;
            end
        end
    end

    logic [NUM_KEYS-1:0] sel_q;
    logic                sel_chg_q;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            sel_q     <= RESET_SEL;
            sel_chg_q <= 1'b0;
        end else if (hit) begin
            sel_q     <= sel_nxt;
            sel_chg_q <= (sel_nxt != sel_q);
        end else begin
            sel_chg_q <= 1'b0;
        end
    end

    assign bus.key_press = press_v;
    assign bus.key_long  = long_v;
    assign bus.key_rep   = rep_v;
    assign bus.key_level = level_v;
    assign bus.sel       = sel_q;
    assign bus.sel_chg   = sel_chg_q;

endmodule
